// File: rtl/fb_scheduler_pkg.sv
// Shared definitions for the framebuffer scheduler: FSM state encoding and pixel colour width.
package fb_scheduler_pkg;

   localparam int RGB_W  = 3;
   localparam int DROP_W = 8;

   typedef enum logic [1:0] {
      S_DRAIN = 2'd0,
      S_CLEAR = 2'd1
   } state_e;

endpackage

// File: rtl/fb_addr_gen.sv
// Maps an (x, y) coordinate to a linear framebuffer address (row-major, RESOLUTION_H pixels per row).
module fb_addr_gen #(
   parameter int RESOLUTION_H = 640,
   parameter int HPOS_WIDTH   = 10,
   parameter int VPOS_WIDTH   = 9,
   parameter int ADDR_WIDTH   = 19
) (
   input  logic [HPOS_WIDTH-1:0] x_i,
   input  logic [VPOS_WIDTH-1:0] y_i,
   output logic [ADDR_WIDTH-1:0] addr_o
);

   // Full-width operands so in-range coordinates never lose product bits.
   assign addr_o = ADDR_WIDTH'(y_i) * ADDR_WIDTH'(RESOLUTION_H) + ADDR_WIDTH'(x_i);

endmodule

// File: rtl/fb_scheduler.sv
// Arbitrates a single-port framebuffer between video scan-out, brush FIFO draining and clear sweeps.
module fb_scheduler
   import fb_scheduler_pkg::*;
#(
   parameter int               RESOLUTION_H   = 640,
   parameter int               RESOLUTION_V   = 480,
   parameter int               HPOS_WIDTH     = 10,
   parameter int               VPOS_WIDTH     = 9,
   parameter int               ADDR_WIDTH     = $clog2(RESOLUTION_H*RESOLUTION_V),
   parameter logic [RGB_W-1:0] CLEAR_COLOR    = 3'b000,
   parameter bit               CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  display_on,
   input  logic [HPOS_WIDTH-1:0] hpos,
   input  logic [VPOS_WIDTH-1:0] vpos,
   input  logic                  fifo_empty,
   input  logic [HPOS_WIDTH-1:0] fifo_x,
   input  logic [VPOS_WIDTH-1:0] fifo_y,
   input  logic [RGB_W-1:0]      fifo_rgb,
   output logic                  fifo_pop,
   input  logic                  clear_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [RGB_W-1:0]      mem_wdata,
   input  logic [RGB_W-1:0]      mem_rdata,
   output logic [RGB_W-1:0]      fb_rgb,
   output logic                  memenable,
   output logic                  clear_busy,
   output logic [DROP_W-1:0]     drop_cnt
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RESOLUTION_H*RESOLUTION_V - 1);
   localparam logic [HPOS_WIDTH:0]   H_LIMIT   = (HPOS_WIDTH+1)'(RESOLUTION_H);
   localparam logic [VPOS_WIDTH:0]   V_LIMIT   = (VPOS_WIDTH+1)'(RESOLUTION_V);
   localparam state_e                RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_DRAIN;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clearCnt_q, clearCnt_d;
   logic [DROP_W-1:0]     dropCnt_q, dropCnt_d;
   logic                  dispDly_q;
   logic [RGB_W-1:0]      fbRgb_q;

   logic [ADDR_WIDTH-1:0] videoAddr;
   logic [ADDR_WIDTH-1:0] fifoAddr;
   logic                  fifoInRange;
   logic                  popRaw;
   logic                  weRaw;

   fb_addr_gen #(
      .RESOLUTION_H (RESOLUTION_H),
      .HPOS_WIDTH   (HPOS_WIDTH),
      .VPOS_WIDTH   (VPOS_WIDTH),
      .ADDR_WIDTH   (ADDR_WIDTH)
   ) uVideoAddr (
      .x_i    (hpos),
      .y_i    (vpos),
      .addr_o (videoAddr)
   );

   fb_addr_gen #(
      .RESOLUTION_H (RESOLUTION_H),
      .HPOS_WIDTH   (HPOS_WIDTH),
      .VPOS_WIDTH   (VPOS_WIDTH),
      .ADDR_WIDTH   (ADDR_WIDTH)
   ) uFifoAddr (
      .x_i    (fifo_x),
      .y_i    (fifo_y),
      .addr_o (fifoAddr)
   );

   assign fifoInRange = ({1'b0, fifo_x} < H_LIMIT) && ({1'b0, fifo_y} < V_LIMIT);

   // Video owns the port whenever display_on is high; otherwise the FSM drains or sweeps.
   always_comb begin
      state_d    = state_q;
      clearCnt_d = clearCnt_q;
      dropCnt_d  = dropCnt_q;
      popRaw     = 1'b0;
      weRaw      = 1'b0;
      mem_addr   = videoAddr;
      mem_wdata  = '0;
      case (state_q)
         S_DRAIN: begin
            if (clear_req) begin
               state_d    = S_CLEAR;
               clearCnt_d = '0;
            end else if (!display_on && !fifo_empty) begin
               popRaw = 1'b1;
               if (fifoInRange) begin
                  weRaw     = 1'b1;
                  mem_addr  = fifoAddr;
                  mem_wdata = fifo_rgb;
               end else if (dropCnt_q != {DROP_W{1'b1}}) begin
                  dropCnt_d = dropCnt_q + DROP_W'(1);
               end
            end
         end
         S_CLEAR: begin
            if (!display_on) begin
               weRaw     = 1'b1;
               mem_addr  = clearCnt_q;
               mem_wdata = CLEAR_COLOR;
               if (clearCnt_q == LAST_ADDR) begin
                  state_d = S_DRAIN;
               end else begin
                  clearCnt_d = clearCnt_q + ADDR_WIDTH'(1);
               end
            end
         end
         default: state_d = S_DRAIN;
      endcase
   end

   // Strobes are gated by reset so nothing is popped or written while reset is low.
   assign fifo_pop = popRaw & reset;
   assign mem_we   = weRaw & reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RESET_STATE;
         clearCnt_q <= '0;
         dropCnt_q  <= '0;
         dispDly_q  <= 1'b0;
         fbRgb_q    <= '0;
      end else begin
         state_q    <= state_d;
         clearCnt_q <= clearCnt_d;
         dropCnt_q  <= dropCnt_d;
         dispDly_q  <= display_on;
         fbRgb_q    <= dispDly_q ? mem_rdata : '0;
      end
   end

   assign fb_rgb     = fbRgb_q;
   assign drop_cnt   = dropCnt_q;
   assign clear_busy = (state_q == S_CLEAR);
   assign memenable  = ~clear_busy;

endmodule

// File: tb/tb_fb_scheduler.sv
// Self-checking bench for fb_scheduler on an 8x4 framebuffer, with a behavioural memory and reference model.
module tb_fb_scheduler;

   localparam int          H   = 8;
   localparam int          V   = 4;
   localparam int          HW  = 4;
   localparam int          VW  = 3;
   localparam int          AW  = 5;
   localparam logic [2:0]  CLR = 3'b010;

   logic          clk = 1'b0;
   logic          reset;
   logic          display_on;
   logic [HW-1:0] hpos;
   logic [VW-1:0] vpos;
   logic          fifo_empty;
   logic [HW-1:0] fifo_x;
   logic [VW-1:0] fifo_y;
   logic [2:0]    fifo_rgb;
   logic          fifo_pop;
   logic          clear_req;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [2:0]    mem_wdata;
   logic [2:0]    mem_rdata;
   logic [2:0]    fb_rgb;
   logic          memenable;
   logic          clear_busy;
   logic [7:0]    drop_cnt;

   fb_scheduler #(
      .RESOLUTION_H   (H),
      .RESOLUTION_V   (V),
      .HPOS_WIDTH     (HW),
      .VPOS_WIDTH     (VW),
      .ADDR_WIDTH     (AW),
      .CLEAR_COLOR    (CLR),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .display_on (display_on),
      .hpos       (hpos),
      .vpos       (vpos),
      .fifo_empty (fifo_empty),
      .fifo_x     (fifo_x),
      .fifo_y     (fifo_y),
      .fifo_rgb   (fifo_rgb),
      .fifo_pop   (fifo_pop),
      .clear_req  (clear_req),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .fb_rgb     (fb_rgb),
      .memenable  (memenable),
      .clear_busy (clear_busy),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   // Single-port framebuffer with a one-cycle synchronous read.
   logic [2:0] mem [0:H*V-1];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // Reference model: sweep position, drop tally, expected framebuffer contents, fb_rgb pipeline.
   bit mClearing;
   int mIdx, mDrops;
   int mFb [H*V];
   int fbPipe1, fbPipe2;
   int ePop, eWe, eAddr, eWd;
   int checks = 0;
   int errors = 0;

   logic          obsPop, obsWe, obsBusy;
   logic [AW-1:0] obsAddr;
   logic [2:0]    obsWd, obsFb;

   typedef struct {
      bit disp;
      bit empty;
      int x;
      int y;
      int rgb;
      bit expPop;
      bit expWe;
      int expAddr;
      int expWd;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mClearing = 1'b1;
      mIdx      = 0;
      mDrops    = 0;
      fbPipe1   = 0;
      fbPipe2   = 0;
   endtask

   task automatic checkOutput(input bit disp, input int hp, input int vp);
      obsPop  = fifo_pop;
      obsWe   = mem_we;
      obsAddr = mem_addr;
      obsWd   = mem_wdata;
      obsFb   = fb_rgb;
      obsBusy = clear_busy;
      check("fifo_pop", fifo_pop, ePop);
      check("mem_we", mem_we, eWe);
      if (eWe != 0) begin
         check("mem_addr", mem_addr, eAddr);
         check("mem_wdata", mem_wdata, eWd);
      end
      if (disp) check("video_addr", mem_addr, vp*H + hp);
      check("clear_busy", clear_busy, mClearing);
      check("memenable", memenable, !mClearing);
      check("drop_cnt", drop_cnt, mDrops);
      check("fb_rgb", fb_rgb, fbPipe2);
   endtask

   // Called at posedge+1: drives one cycle, checks at the falling edge, returns at the next posedge+1.
   task automatic applyStimulus(input bit disp, input bit empty, input int x, input int y,
                                input int rgb, input bit creq, input int hp, input int vp);
      int rdExp;
      display_on = disp;
      fifo_empty = empty;
      fifo_x     = HW'(x);
      fifo_y     = VW'(y);
      fifo_rgb   = 3'(rgb);
      clear_req  = creq;
      hpos       = HW'(hp);
      vpos       = VW'(vp);
      ePop = 0; eWe = 0; eAddr = 0; eWd = 0;
      if (!mClearing && !creq && !disp && !empty) begin
         ePop = 1;
         if (x < H && y < V) begin
            eWe = 1; eAddr = y*H + x; eWd = rgb;
         end
      end else if (mClearing && !disp) begin
         eWe = 1; eAddr = mIdx; eWd = CLR;
      end
      rdExp = disp ? mFb[vp*H + hp] : 0;
      #4;
      checkOutput(disp, hp, vp);
      if (eWe != 0) mFb[eAddr] = eWd;
      if (ePop != 0 && eWe == 0 && mDrops < 255) mDrops++;
      if (mClearing && eWe != 0) begin
         mIdx++;
         if (mIdx == H*V) mClearing = 1'b0;
      end else if (!mClearing && creq) begin
         mClearing = 1'b1;
         mIdx      = 0;
      end
      fbPipe2 = fbPipe1;
      fbPipe1 = rdExp;
      @(posedge clk);
      #1;
   endtask

   task automatic runSweep(input string tag);
      for (int i = 0; i < H*V; i++) begin
         applyStimulus(1'b0, 1'b1, 0, 0, 0, 1'b0, 0, 0);
         check({tag, "_addr"}, obsAddr, i);
         check({tag, "_we"}, obsWe, 1);
         check({tag, "_wdata"}, obsWd, CLR);
      end
      check({tag, "_busy_end"}, clear_busy, 0);
      check({tag, "_memenable_end"}, memenable, 1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs [8];
      int   nextAddr;
      int   n;

      for (int i = 0; i < H*V; i++) begin
         mem[i] = 3'b000;
         mFb[i] = 0;
      end
      mem_rdata  = 3'b000;
      reset      = 1'b0;
      display_on = 1'b0;
      fifo_empty = 1'b0;
      fifo_x     = 4'd3;
      fifo_y     = 3'd2;
      fifo_rgb   = 3'd5;
      clear_req  = 1'b0;
      hpos       = '0;
      vpos       = '0;
      modelReset();

      // Reset state, with a sweep and a FIFO head pending so the strobes must be held off.
      repeat (3) @(posedge clk);
      #1;
      check("rst_fifo_pop", fifo_pop, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_fb_rgb", fb_rgb, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_clear_busy", clear_busy, 1);
      check("rst_memenable", memenable, 0);

      reset = 1'b1;
      runSweep("init_sweep");

      // Out-of-range entries are dropped and counted, saturating at 255.
      applyStimulus(1'b0, 1'b0, 8, 0, 3, 1'b0, 0, 0);
      check("drop_pop", obsPop, 1);
      check("drop_we", obsWe, 0);
      check("drop_cnt_1", drop_cnt, 1);
      for (int i = 0; i < 299; i++) applyStimulus(1'b0, 1'b0, 8, 0, 3, 1'b0, 0, 0);
      check("drop_cnt_sat", drop_cnt, 255);

      vecs[0] = '{1'b0, 1'b0, 3, 2, 5, 1'b1, 1'b1, 19, 5};
      vecs[1] = '{1'b0, 1'b0, 8, 0, 1, 1'b1, 1'b0, 0, 0};
      vecs[2] = '{1'b1, 1'b0, 3, 2, 5, 1'b0, 1'b0, 0, 0};
      vecs[3] = '{1'b0, 1'b1, 3, 2, 5, 1'b0, 1'b0, 0, 0};
      vecs[4] = '{1'b0, 1'b0, 7, 3, 6, 1'b1, 1'b1, 31, 6};
      vecs[5] = '{1'b0, 1'b0, 0, 0, 1, 1'b1, 1'b1, 0, 1};
      vecs[6] = '{1'b0, 1'b0, 2, 4, 7, 1'b1, 1'b0, 0, 0};
      vecs[7] = '{1'b0, 1'b0, 5, 1, 6, 1'b1, 1'b1, 13, 6};
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].disp, vecs[i].empty, vecs[i].x, vecs[i].y, vecs[i].rgb, 1'b0, 1, 1);
         check($sformatf("vec%0d_pop", i), obsPop, vecs[i].expPop);
         check($sformatf("vec%0d_we", i), obsWe, vecs[i].expWe);
         if (vecs[i].expWe) begin
            check($sformatf("vec%0d_addr", i), obsAddr, vecs[i].expAddr);
            check($sformatf("vec%0d_wdata", i), obsWd, vecs[i].expWd);
         end
      end

      // Video read of (5,1) just written with 3'b110 appears on fb_rgb two cycles later.
      applyStimulus(1'b1, 1'b1, 0, 0, 0, 1'b0, 5, 1);
      applyStimulus(1'b0, 1'b1, 0, 0, 0, 1'b0, 0, 0);
      applyStimulus(1'b0, 1'b1, 0, 0, 0, 1'b0, 0, 0);
      check("video_fb_rgb", obsFb, 3'b110);

      // Long active-video stretch holds the FIFO off; draining resumes immediately afterwards.
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, 1'b0, 1, 1, 4, 1'b0, i % H, (i / H) % V);
         check("active_no_pop", obsPop, 0);
         check("active_no_we", obsWe, 0);
      end
      applyStimulus(1'b0, 1'b0, 1, 1, 4, 1'b0, 0, 0);
      check("resume_pop", obsPop, 1);
      check("resume_addr", obsAddr, 9);

      // Clear requested mid-drain, display toggling every 10 cycles, a repeat request ignored.
      applyStimulus(1'b0, 1'b0, 2, 2, 1, 1'b1, 0, 0);
      check("clrreq_no_pop", obsPop, 0);
      nextAddr = 0;
      n = 0;
      while (clear_busy && n < 300) begin
         applyStimulus(((n / 10) % 2) == 1, 1'b0, 2, 2, 1, n == 15, n % H, n % V);
         if (obsWe) begin
            check("sweep_contiguous", obsAddr, nextAddr);
            check("sweep_only_blank", (n / 10) % 2, 0);
            nextAddr++;
         end
         check("sweep_no_pop", obsPop, 0);
         n++;
      end
      check("sweep_finished", clear_busy, 0);
      check("sweep_count", nextAddr, H*V);

      // Randomised traffic against the reference model.
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 9), $urandom_range(0, 4), $urandom_range(0, 7),
                       $urandom_range(0, 99) == 0, $urandom_range(0, H-1), $urandom_range(0, V-1));
      end

      // Force a fresh sweep, then abort it with reset part-way through.
      while (clear_busy) applyStimulus(1'b0, 1'b1, 0, 0, 0, 1'b0, 0, 0);
      applyStimulus(1'b0, 1'b1, 0, 0, 0, 1'b1, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 0, 0, 0, 1'b0, 0, 0);
      check("midsweep_we_before", mem_we, 1);
      reset = 1'b0;
      #1;
      check("midsweep_rst_we", mem_we, 0);
      check("midsweep_rst_pop", fifo_pop, 0);
      check("midsweep_rst_drop", drop_cnt, 0);
      check("midsweep_rst_fb", fb_rgb, 0);
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      runSweep("rst_sweep");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
